// File: rtl/pmem_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into 32-bit words,
// writes them to program memory from address 0 and holds the CPU in reset until done.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module pmem_loader #(
    parameter int PC_WIDTH = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                pmem_w_en,
    output logic [PC_WIDTH-1:0] pmem_addr,
    output logic [31:0]         pmem_w_data,
    output logic                cpu_rst,
    output logic                busy,
    output logic                done,
    output logic                error
);
    localparam int WW = PC_WIDTH - 2;
    localparam logic [16:0] MAX_WORDS = 17'(1) << WW;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        DONE     = 3'd5,
        ERR      = 3'd6
`ifdef LOADER_CHECKSUM_EN
        ,S_CSUM  = 3'd7
`endif
    } state_t;

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    // one extra bit so a full-capacity load can count past the last word
    logic [WW:0] word_idx;
    logic [1:0]  byte_idx;
    logic [31:0] word_buf;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum;
`endif

    logic        take;
    logic [15:0] len_rx;
    logic [16:0] next_cnt;

    assign take     = in_valid && in_ready;
    assign len_rx   = {in_data, len_lo};
    assign next_cnt = 17'(word_idx) + 17'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            len_lo   <= '0;
            len      <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            word_buf <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= S_LEN_LO;
                        word_idx <= '0;
                        byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum      <= '0;
`endif
                    end
                end
                S_LEN_LO: begin
                    if (take) begin
                        len_lo <= in_data;
                        state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (take) begin
                        len <= len_rx;
                        if ({1'b0, len_rx} > MAX_WORDS)
                            state <= ERR;
                        else if (len_rx == 16'd0)
`ifdef LOADER_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state <= DONE;
`endif
                        else
                            state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (take) begin
                        word_buf[{byte_idx, 3'b000} +: 8] <= in_data;
                        byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum      <= sum + in_data;
`endif
                        if (byte_idx == 2'd3)
                            state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    if (next_cnt == {1'b0, len})
`ifdef LOADER_CHECKSUM_EN
                        state <= S_CSUM;
`else
                        state <= DONE;
`endif
                    else
                        state <= S_DATA;
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (take)
                        state <= (in_data == sum) ? DONE : ERR;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // every output is a pure decode of registered state
    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_LEN_LO, S_LEN_HI, S_DATA: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:                     in_ready = 1'b1;
`endif
            default:                    in_ready = 1'b0;
        endcase
    end

    assign pmem_w_en   = (state == S_WRITE);
    assign pmem_addr   = {word_idx[WW-1:0], 2'b00};
    assign pmem_w_data = word_buf;
    assign cpu_rst     = (state != DONE);
    assign done        = (state == DONE);
    assign error       = (state == ERR);
    assign busy        = !((state == IDLE) || (state == DONE) || (state == ERR));

endmodule

// File: tb/tb_pmem_loader.sv
// Directed bench for pmem_loader: basic load, gaps, oversize, zero length,
// mid-load reset, and (when LOADER_CHECKSUM_EN is defined) checksum failure.
module tb_pmem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        pmem_w_en;
    logic [11:0] pmem_addr;
    logic [31:0] pmem_w_data;
    logic        cpu_rst, busy, done, error;

    int n_assert = 0;
    int n_fail   = 0;

    int          wr_count = 0;
    int          overlap  = 0;
    logic [11:0] wr_addr [64];
    logic [31:0] wr_data [64];

    logic [7:0] basic [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                               8'h93, 8'h00, 8'h10, 8'h00};

    pmem_loader #(.PC_WIDTH(12)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .pmem_w_en(pmem_w_en), .pmem_addr(pmem_addr),
        .pmem_w_data(pmem_w_data), .cpu_rst(cpu_rst), .busy(busy), .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pmem_w_en) begin
            if (wr_count < 64) begin
                wr_addr[wr_count] = pmem_addr;
                wr_data[wr_count] = pmem_w_data;
            end
            wr_count = wr_count + 1;
        end
        if (pmem_w_en && in_ready) overlap = overlap + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_end();
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (done || error) ok = 1'b1;
            else tick();
        end
        if (!ok) check("end_timeout", 32'(ok), 32'd1);
    endtask

    task automatic basic_load(input string tag, input bit gaps, input logic [7:0] csum);
        int base;
        base = wr_count;
        pulse_start();
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_cpu_rst_load"}, 32'(cpu_rst), 32'd1);
        for (int i = 0; i < 10; i++)
            send_byte(basic[i], gaps ? int'($urandom_range(0, 5)) : 0);
        // last payload byte just taken: the write is on the bus, CPU still held
        check({tag, "_last_wen"}, 32'(pmem_w_en), 32'd1);
        check({tag, "_last_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_not_done_yet"}, 32'(done), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        tick();
        send_byte(csum, 0);
`else
        tick();
        check({tag, "_csum_unused"}, 32'(csum), 32'h0);
`endif
        wait_end();
        check({tag, "_nwrites"}, 32'(wr_count - base), 32'd2);
        check({tag, "_addr0"}, 32'(wr_addr[base]), 32'h000);
        check({tag, "_data0"}, wr_data[base], 32'h0000_0013);
        check({tag, "_addr1"}, 32'(wr_addr[base+1]), 32'h004);
        check({tag, "_data1"}, wr_data[base+1], 32'h0010_0093);
    endtask

    initial begin
        int base;
        repeat (2) tick();
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_wen", 32'(pmem_w_en), 32'd0);
        check("rst_addr", 32'(pmem_addr), 32'd0);
        check("rst_wdata", pmem_w_data, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        rst = 1'b0;
        tick();

        // bytes offered while idle must not be consumed
        in_valid = 1'b1; in_data = 8'h55;
        tick();
        check("idle_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

`ifdef LOADER_CHECKSUM_EN
        basic_load("basic", 1'b0, 8'hB6);
`else
        basic_load("basic", 1'b0, 8'h00);
`endif
        check("basic_done", 32'(done), 32'd1);
        check("basic_cpu_rst", 32'(cpu_rst), 32'd0);
        check("basic_error", 32'(error), 32'd0);
        check("basic_busy", 32'(busy), 32'd0);

        // restart from DONE must reassert cpu_rst next cycle
`ifdef LOADER_CHECKSUM_EN
        basic_load("gaps", 1'b1, 8'hB6);
`else
        basic_load("gaps", 1'b1, 8'h00);
`endif
        check("gaps_done", 32'(done), 32'd1);
        check("gaps_overlap", 32'(overlap), 32'd0);

        // oversize: N = 1025 > 1024 words
        base = wr_count;
        pulse_start();
        check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        check("over_error", 32'(error), 32'd1);
        check("over_cpu_rst", 32'(cpu_rst), 32'd1);
        check("over_ready", 32'(in_ready), 32'd0);
        check("over_done", 32'(done), 32'd0);
        tick();
        check("over_nwrites", 32'(wr_count - base), 32'd0);

        // zero length
        pulse_start();
        check("zero_clear_err", 32'(error), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        check("zero_done", 32'(done), 32'd1);
        check("zero_cpu_rst", 32'(cpu_rst), 32'd0);
        check("zero_nwrites", 32'(wr_count - base), 32'd0);

        // maximum length accepted, then reset after two payload bytes
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        check("max_error", 32'(error), 32'd0);
        check("max_ready", 32'(in_ready), 32'd1);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("mid_rst_wdata", pmem_w_data, 32'd0);
        check("mid_rst_addr", 32'(pmem_addr), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_rst_nwrites", 32'(wr_count - base), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        basic_load("after_rst", 1'b0, 8'hB6);
`else
        basic_load("after_rst", 1'b0, 8'h00);
`endif
        check("after_rst_done", 32'(done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        basic_load("badsum", 1'b0, 8'hB7);
        check("badsum_error", 32'(error), 32'd1);
        check("badsum_done", 32'(done), 32'd0);
        check("badsum_cpu_rst", 32'(cpu_rst), 32'd1);
        basic_load("reload", 1'b0, 8'hB6);
        check("reload_done", 32'(done), 32'd1);
        check("reload_error", 32'(error), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
